// File: rtl/simon_pkg.sv
// Shared types and constants for the colour-sequence game datapath.
// Colour encoding, LED one-hot mapping, sequence depth and LFSR feedback taps.
package simon_pkg;

    localparam int unsigned MAX_ROUNDS = 32;

    // Galois right-shift feedback for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    typedef logic [2:0] speed_t;

    function automatic logic [3:0] onehot(input colour_t c);
        onehot = 4'b0001 << c;
    endfunction

endpackage

// File: rtl/sequence_datapath_pulse_timer.sv
// Periodic one-cycle tick, period = max(BASE_PERIOD >> speed_q, MIN_PERIOD) cycles.
// Registered pulse output; restart reloads the count and suppresses the tick; no backpressure.
module pulse_timer
    import simon_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 25_000_000,
    parameter int unsigned MIN_PERIOD  = 1_000_000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   restart,
    input  speed_t speed_q,
    output logic   pulse
);

    logic [31:0] w_scaled;
    logic [31:0] w_period;
    logic [31:0] r_timer;
    logic        r_pulse;

    assign w_scaled = 32'(BASE_PERIOD) >> speed_q;
    assign w_period = (w_scaled < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : w_scaled;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= 32'(BASE_PERIOD) - 32'd1;
            r_pulse <= 1'b0;
        end else if (restart) begin
            r_timer <= w_period - 32'd1;
            r_pulse <= 1'b0;
        end else if (r_timer == 32'd0) begin
            r_timer <= w_period - 32'd1;
            r_pulse <= 1'b1;
        end else begin
            r_timer <= r_timer - 32'd1;
            r_pulse <= 1'b0;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/sequence_datapath.sv
// Command-driven responder: seed/LFSR colour generation, sequence store, LED flash, press compare.
// LED one cycle after flash_clk, result combinational, pulse registered; commands always accepted.
module sequence_datapath
    import simon_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 25_000_000,
    parameter int unsigned MIN_PERIOD  = 1_000_000,
    parameter int unsigned LFSR_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst_seedgen,
    input  logic       start,
    input  logic       load_colour,
    input  logic       load_speed,
    input  logic [2:0] speed,
    input  logic       flash_clk,
    input  logic [5:0] check_round,
    input  logic [5:0] current_round,
    input  logic [3:0] player_input,
    output logic       pulse,
    output logic       result,
    output logic [3:0] led
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    logic [LFSR_W-1:0] r_seed;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_step;
    speed_t            r_speed_q;
    colour_t           r_seq [MAX_ROUNDS];
    logic [3:0]        r_led;
    logic [3:0]        r_press;
    logic [5:0]        r_check_prev;
    logic              w_valid;
    logic [4:0]        w_idx;
    logic [3:0]        w_sel_oh;
    logic              w_write;

    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

    assign w_valid  = (check_round != 6'd0) && (check_round <= current_round);
    assign w_idx    = current_round[4:0] - check_round[4:0];
    assign w_sel_oh = onehot(r_seq[w_idx]);
    assign w_write  = load_colour && (current_round < 6'(MAX_ROUNDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seed <= '0;
            r_lfsr <= '0;
        end else begin
            r_seed <= rst_seedgen ? '0 : r_seed + LFSR_W'(1);
            // A start loads from the pre-clear seed, forced odd so the LFSR never locks at zero.
            if (start)
                r_lfsr <= r_seed | LFSR_W'(1);
            else if (load_colour)
                r_lfsr <= w_lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MAX_ROUNDS); i++)
                r_seq[i] <= RED;
        end else if (w_write) begin
            r_seq[current_round[4:0]] <= colour_t'(w_lfsr_step[1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_speed_q    <= '0;
            r_led        <= 4'b0000;
            r_press      <= 4'b0000;
            r_check_prev <= 6'd0;
        end else begin
            if (load_speed)
                r_speed_q <= speed;
            r_led <= (flash_clk && w_valid) ? w_sel_oh : 4'b0000;
            // A new segment discards any press captured against the previous one.
            if (check_round != r_check_prev)
                r_press <= 4'b0000;
            else if (player_input != 4'b0000)
                r_press <= player_input;
            r_check_prev <= check_round;
        end
    end

    pulse_timer #(
        .BASE_PERIOD (BASE_PERIOD),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_pulse_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (start | load_speed),
        .speed_q (r_speed_q),
        .pulse   (pulse)
    );

    assign result = w_valid && (r_press == w_sel_oh);
    assign led    = r_led;

endmodule

// File: tb/tb_sequence_datapath.sv
// Directed bench for sequence_datapath with a cycle-level reference model and literal spot checks.
module tb_sequence_datapath;
    import simon_pkg::*;

    localparam int BP = 8;
    localparam int MP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_seedgen = 1'b0;
    logic       start = 1'b0;
    logic       load_colour = 1'b0;
    logic       load_speed = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       flash_clk = 1'b0;
    logic [5:0] check_round = 6'd0;
    logic [5:0] current_round = 6'd0;
    logic [3:0] player_input = 4'd0;
    logic       pulse;
    logic       result;
    logic [3:0] led;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sequence_datapath #(
        .BASE_PERIOD (BP),
        .MIN_PERIOD  (MP),
        .LFSR_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .rst_seedgen   (rst_seedgen),
        .start         (start),
        .load_colour   (load_colour),
        .load_speed    (load_speed),
        .speed         (speed),
        .flash_clk     (flash_clk),
        .check_round   (check_round),
        .current_round (current_round),
        .player_input  (player_input),
        .pulse         (pulse),
        .result        (result),
        .led           (led)
    );

    // Reference model state
    int          m_seed;
    logic [15:0] m_lfsr;
    int          m_seq [32];
    int          m_speed;
    logic [3:0]  m_press;
    logic [3:0]  m_led;
    logic [5:0]  m_prev;
    int          m_edge;
    int          m_due;
    logic        m_pulse;

    function automatic int period_of(input int s);
        int p;
        p = BP >> s;
        return (p < MP) ? MP : p;
    endfunction

    function automatic logic [3:0] oh_of(input int c);
        return 4'b0001 << c;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic bit sel_valid(input logic [5:0] chk, input logic [5:0] cur);
        return (chk != 0) && (chk <= cur);
    endfunction

    function automatic int sel_idx(input logic [5:0] chk, input logic [5:0] cur);
        return (int'(cur) - int'(chk)) & 31;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] nl;
        int          old_speed;
        int          idx;
        if (!rst_n) begin
            m_seed = 0;
            m_lfsr = 16'h0;
            foreach (m_seq[i]) m_seq[i] = 0;
            m_speed = 0;
            m_press = 4'h0;
            m_led = 4'h0;
            m_prev = 6'd0;
            m_edge = 0;
            m_due = BP;
            m_pulse = 1'b0;
        end else begin
            old_speed = m_speed;
            m_edge++;
            idx = sel_idx(check_round, current_round);
            m_led = (flash_clk && sel_valid(check_round, current_round)) ? oh_of(m_seq[idx]) : 4'h0;
            if (check_round != m_prev) m_press = 4'h0;
            else if (player_input != 4'h0) m_press = player_input;
            m_prev = check_round;
            nl = galois(m_lfsr);
            if (load_colour && current_round < 6'd32) m_seq[current_round] = int'(nl[1:0]);
            if (start) m_lfsr = 16'(m_seed) | 16'h1;
            else if (load_colour) m_lfsr = nl;
            m_seed = rst_seedgen ? 0 : ((m_seed + 1) & 16'hFFFF);
            if (load_speed) m_speed = int'(speed);
            m_pulse = 1'b0;
            if (start || load_speed) m_due = m_edge + period_of(old_speed);
            else if (m_edge == m_due) begin
                m_pulse = 1'b1;
                m_due = m_edge + period_of(old_speed);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_res;
        if (rst_n) begin
            exp_res = sel_valid(check_round, current_round) &&
                      (m_press == oh_of(m_seq[sel_idx(check_round, current_round)]));
            check("model_led", 32'(led), 32'(m_led));
            check("model_pulse", 32'(pulse), 32'(m_pulse));
            check("model_result", 32'(result), 32'(exp_res));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counts edges until pulse is seen; exp_gap <= 0 only requires that a pulse arrives.
    task automatic wait_pulse(input string name, input int exp_gap);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (pulse) seen = 1;
        end
        if (exp_gap > 0) check(name, 32'(n), 32'(exp_gap));
        else check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #12;
        check("reset_led", 32'(led), 32'd0);
        check("reset_pulse", 32'(pulse), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        tick();
        rst_n = 1'b1;

        // Pulse timer at base period, then scaled and clamped
        wait_pulse("first_pulse", 8);
        wait_pulse("gap_base", 8);
        tick();
        load_speed = 1'b1; speed = 3'd2;
        tick();
        load_speed = 1'b0;
        wait_pulse("sync_speed2", 0);
        wait_pulse("gap_speed2_a", 2);
        wait_pulse("gap_speed2_b", 2);
        tick();
        load_speed = 1'b1; speed = 3'd5;
        tick();
        load_speed = 1'b0;
        wait_pulse("sync_speed5", 0);
        wait_pulse("gap_speed5", 2);

        // Seed 0x000B then three colours, plus an out-of-range write
        tick();
        rst_seedgen = 1'b1;
        tick();
        rst_seedgen = 1'b0;
        repeat (11) tick();
        start = 1'b1;
        tick();
        start = 1'b0; load_colour = 1'b1; current_round = 6'd0;
        tick();
        current_round = 6'd1;
        tick();
        current_round = 6'd2;
        tick();
        current_round = 6'd32;
        tick();
        load_colour = 1'b0;

        // Flash entries 0..2: GREEN, BLUE, GREEN from seed 0x000B
        current_round = 6'd3; check_round = 6'd3; flash_clk = 1'b1;
        tick();
        flash_clk = 1'b0;
        @(negedge clk);
        check("led_entry0", 32'(led), 32'h2);
        tick();
        check_round = 6'd2; flash_clk = 1'b1;
        tick();
        flash_clk = 1'b0;
        @(negedge clk);
        check("led_entry1", 32'(led), 32'h4);
        tick();
        check_round = 6'd1; flash_clk = 1'b1;
        tick();
        flash_clk = 1'b0;
        @(negedge clk);
        check("led_entry2", 32'(led), 32'h2);
        tick();
        check_round = 6'd0; flash_clk = 1'b1;
        tick();
        flash_clk = 1'b0;
        @(negedge clk);
        check("led_none", 32'(led), 32'h0);

        // Press capture against entry1 (BLUE), held after release, cleared on segment change
        tick();
        check_round = 6'd2;
        tick();
        player_input = 4'b0100;
        tick();
        player_input = 4'b0000;
        tick();
        @(negedge clk);
        check("press_match", 32'(result), 32'd1);
        tick();
        @(negedge clk);
        check("press_held", 32'(result), 32'd1);
        tick();
        check_round = 6'd1;
        tick();
        @(negedge clk);
        check("press_cleared", 32'(result), 32'd0);

        // Multi-key press against entry0 (GREEN), then a correct press, then an invalid select
        tick();
        check_round = 6'd3;
        tick();
        player_input = 4'b0110;
        tick();
        player_input = 4'b0000;
        tick();
        @(negedge clk);
        check("multikey", 32'(result), 32'd0);
        tick();
        player_input = 4'b0010;
        tick();
        player_input = 4'b0000;
        tick();
        @(negedge clk);
        check("single_key", 32'(result), 32'd1);
        tick();
        current_round = 6'd2; check_round = 6'd5; flash_clk = 1'b1;
        tick();
        player_input = 4'b0010;
        tick();
        player_input = 4'b0000; flash_clk = 1'b0;
        @(negedge clk);
        check("invalid_result", 32'(result), 32'd0);
        check("invalid_led", 32'(led), 32'd0);

        // Asynchronous reset mid-count with load_colour active
        tick();
        current_round = 6'd3; check_round = 6'd3; flash_clk = 1'b1; load_colour = 1'b1;
        tick();
        tick();
        check("led_pre_rst", 32'(led), 32'h2);
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_pulse", 32'(pulse), 32'd0);
        tick();
        tick();
        load_colour = 1'b0; flash_clk = 1'b0; check_round = 6'd0; current_round = 6'd0;
        rst_n = 1'b1;
        wait_pulse("post_rst_pulse", 8);
        tick();
        current_round = 6'd1; check_round = 6'd1; flash_clk = 1'b1;
        tick();
        flash_clk = 1'b0;
        @(negedge clk);
        check("rst_entry0", 32'(led), 32'h1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
